// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encodings, the invalid
// destination address and the number of destination ports.
package router_pkg;

  localparam int NUM_PORTS = 3;

  // Address 2'b11 has no destination FIFO behind it.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 packet router. This Moore machine decodes the header
// address and sequences the header, payload and parity loads into the
// register stage. It also stalls while the selected destination FIFO is full.
// Optional build macro ROUTER_FSM_DBG_EN adds two debug outputs: state_dbg,
// which mirrors the state register, and pkt_cnt, a count of completed packets.
module router_ctrl_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
`ifdef ROUTER_FSM_DBG_EN
  output logic [2:0] state_dbg,
  output logic [7:0] pkt_cnt,
`endif
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_addr_q;
  logic       w_empty_sel;
  logic       w_empty_din;
  logic       w_soft_reset_sel;

  // Select the per-port empty and soft-reset flags. Two sources pick the port:
  // the latched address, and the live header address seen while decoding.
  always_comb begin
    w_empty_sel      = 1'b0;
    w_soft_reset_sel = 1'b0;
    w_empty_din      = 1'b0;
    case (r_addr_q)
      2'd0: begin w_empty_sel = fifo_empty_0; w_soft_reset_sel = soft_reset_0; end
      2'd1: begin w_empty_sel = fifo_empty_1; w_soft_reset_sel = soft_reset_1; end
      2'd2: begin w_empty_sel = fifo_empty_2; w_soft_reset_sel = soft_reset_2; end
      default: ;
    endcase
    case (data_in)
      2'd0: w_empty_din = fifo_empty_0;
      2'd1: w_empty_din = fifo_empty_1;
      2'd2: w_empty_din = fifo_empty_2;
      default: ;
    endcase
  end

  // Next-state logic. A soft reset on the selected port aborts any packet in flight.
  always_comb begin
    w_state_next = r_state;
    if (r_state != DECODE_ADDRESS && w_soft_reset_sel) begin
      w_state_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != ADDR_INVALID)
            w_state_next = w_empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (w_empty_sel) w_state_next = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          w_state_next = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       w_state_next = FIFO_FULL_STATE;
          else if (!pkt_valid) w_state_next = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) w_state_next = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)           w_state_next = DECODE_ADDRESS;
          else if (low_packet_valid) w_state_next = LOAD_PARITY;
          else                       w_state_next = LOAD_DATA;
        LOAD_PARITY:
          w_state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          w_state_next = DECODE_ADDRESS;
      endcase
    end
  end

  // State register plus destination address latch. The latch captures only valid headers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == DECODE_ADDRESS && pkt_valid && data_in != ADDR_INVALID)
        r_addr_q <= data_in;
    end
  end

  // Moore output decode. Outputs depend on the state register only.
  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_FIRST_DATA) || (r_state == LOAD_DATA) ||
                    (r_state == LOAD_AFTER_FULL) || (r_state == LOAD_PARITY);
    busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  end

`ifdef ROUTER_FSM_DBG_EN
  logic [7:0] r_pkt_cnt;

  // Count packets that finish through the parity check back into address decode.
  always_ff @(posedge clock) begin
    if (reset)
      r_pkt_cnt <= 8'd0;
    else if (r_state == CHECK_PARITY_ERROR && w_state_next == DECODE_ADDRESS)
      r_pkt_cnt <= r_pkt_cnt + 8'd1;
  end

  assign state_dbg = r_state;
  assign pkt_cnt   = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm. A driver applies one directed block
// and then a randomized one. For every driven cycle, a behavioural model
// predicts the outputs the DUT should show after the next edge and pushes
// them into a queue. A monitor pops the queue one edge later and compares.
// When the bench is built with ROUTER_FSM_DBG_EN, it also checks state_dbg
// and pkt_cnt.
module tb_router_ctrl_fsm;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       write_enb_reg, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;
`ifdef ROUTER_FSM_DBG_EN
  logic [2:0] state_dbg;
  logic [7:0] pkt_cnt;
`endif

  router_ctrl_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
`ifdef ROUTER_FSM_DBG_EN
    .state_dbg(state_dbg), .pkt_cnt(pkt_cnt),
`endif
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] outs;   // {we, detect, lfd, ld, laf, full, rst_int, busy}
    logic [2:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     driver_done = 0;

  // Reference model state
  state_t     m_state = DECODE_ADDRESS;
  logic [1:0] m_addr  = 2'd0;
  int         m_cnt   = 0;

  // Expected output vector, written directly from the output rules.
  function automatic logic [7:0] outs_of(state_t s);
    bit we, bz;
    we = (s inside {LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY});
    bz = !(s inside {DECODE_ADDRESS, LOAD_DATA});
    return {we, s == DECODE_ADDRESS, s == LOAD_FIRST_DATA, s == LOAD_DATA,
            s == LOAD_AFTER_FULL, s == FIFO_FULL_STATE, s == CHECK_PARITY_ERROR, bz};
  endfunction

  // Drive one cycle of inputs, advance the model, and queue the expected response.
  task automatic step(input logic pv, input logic [1:0] din, input logic [2:0] emp,
                      input logic full, input logic [2:0] sr, input logic pd,
                      input logic lpv, input logic rst);
    state_t nxt;
    exp_t   e;
    @(negedge clock);
    reset = rst; pkt_valid = pv; data_in = din; fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd; low_packet_valid = lpv;
    nxt = m_state;
    if (rst) begin
      nxt = DECODE_ADDRESS;
      m_addr = 2'd0;
      m_cnt = 0;
    end else if (m_state != DECODE_ADDRESS && sr[m_addr]) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (m_state)
        DECODE_ADDRESS:     if (pv && din != 2'd3) nxt = emp[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:    if (emp[m_addr]) nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:    nxt = LOAD_DATA;
        LOAD_DATA:          nxt = full ? FIFO_FULL_STATE : (!pv ? LOAD_PARITY : LOAD_DATA);
        FIFO_FULL_STATE:    nxt = full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:    nxt = pd ? DECODE_ADDRESS : (lpv ? LOAD_PARITY : LOAD_DATA);
        LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt = full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            nxt = DECODE_ADDRESS;
      endcase
    end
    if (!rst) begin
      if (m_state == CHECK_PARITY_ERROR && nxt == DECODE_ADDRESS) m_cnt = (m_cnt + 1) % 256;
      if (m_state == DECODE_ADDRESS && pv && din != 2'd3) m_addr = din;
    end
    m_state = nxt;
    e.outs = outs_of(nxt);
    e.st   = nxt;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Idle cycle with all side inputs quiet except those given.
  task automatic go(input logic pv, input logic [1:0] din, input logic [2:0] emp,
                    input logic full);
    step(pv, din, emp, full, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one edge after each drive, compare DUT outputs with the queued prediction.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, busy};
        vectors++;
        if (act !== e.outs) begin
          miscompares++;
          $display("FAIL outputs{we,det,lfd,ld,laf,full,rst,busy} vec %0d: got %b expected %b (model state %0d)",
                   vectors, act, e.outs, e.st);
        end else begin
          $display("vec %0d ok: outputs %b state %0d", vectors, act, e.st);
        end
`ifdef ROUTER_FSM_DBG_EN
        if (state_dbg !== e.st || pkt_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL dbg vec %0d: got state %0d cnt %0d expected state %0d cnt %0d",
                   vectors, state_dbg, pkt_cnt, e.st, e.cnt);
        end
`endif
      end else if (driver_done) begin
        break;
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin : driver
    int n;
    step(0, 2'd0, 3'b111, 0, 3'b000, 0, 0, 1);
    step(0, 2'd0, 3'b111, 0, 3'b000, 0, 0, 1);
    // Packet to port 2: header, 5 payload bytes, then parity and check.
    go(1, 2'd2, 3'b100, 0);
    for (int i = 0; i < 5; i++) go(1, 2'd0, 3'b100, 0);
    go(0, 2'd0, 3'b100, 0);
    go(0, 2'd0, 3'b100, 0);
    go(0, 2'd0, 3'b100, 0);
    // Port 1 is not empty for 4 cycles, then drains.
    go(1, 2'd1, 3'b000, 0);
    for (int i = 0; i < 3; i++) go(1, 2'd1, 3'b000, 0);
    go(1, 2'd1, 3'b010, 0);
    go(1, 2'd0, 3'b010, 0);
    // Full stall, then release back to data, then release to parity.
    go(1, 2'd0, 3'b010, 1);
    go(1, 2'd0, 3'b010, 0);
    step(1, 2'd0, 3'b010, 0, 3'b000, 0, 0, 0);
    go(1, 2'd0, 3'b010, 1);
    go(1, 2'd0, 3'b010, 0);
    step(1, 2'd0, 3'b010, 0, 3'b000, 0, 1, 0);
    go(0, 2'd0, 3'b010, 0);
    go(0, 2'd0, 3'b010, 0);
    // Invalid address is ignored.
    go(1, 2'd3, 3'b111, 0);
    go(1, 2'd3, 3'b111, 0);
    // Soft reset: a non-selected port has no effect, the selected port aborts.
    go(1, 2'd2, 3'b100, 0);
    go(1, 2'd0, 3'b100, 0);
    step(1, 2'd0, 3'b100, 0, 3'b001, 0, 0, 0);
    step(1, 2'd0, 3'b100, 0, 3'b100, 0, 0, 0);
    // Randomized traffic.
    n = 3000;
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0,
           {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0},
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end
    driver_done = 1;
    repeat (3) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
